// File: rtl/gf180mcu_nand_pipe.sv
// gf180mcu_nand_pipe: N-lane bitwise NAND/AND reduction behind a DEPTH-stage valid/ready pipeline
// with a wrapping count of delivered results.
module gf180mcu_nand_pipe #(
    parameter int N     = 3,
    parameter int W     = 1,
    parameter int DEPTH = 2,
    parameter int CW    = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N*W-1:0]  A,
    input  logic            MODE,
    input  logic            IVALID,
    output logic            IREADY,
    output logic [W-1:0]    ZN,
    output logic            OVALID,
    input  logic            OREADY,
    output logic [CW-1:0]   XFER_CNT
);
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0][W-1:0] data_q, data_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DEPTH-1:0]        rdy;
    logic [W-1:0]            r;
    logic                    acc;

    always_comb begin
        r = '1;
        for (int k = 0; k < N; k++) r = r & A[k*W +: W];
        // a stage is ready when it or any stage downstream of it is empty, or OREADY is high
        acc = OREADY;
        rdy = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            acc    = !valid_q[i] | acc;
            rdy[i] = acc;
        end
        valid_d = valid_q;
        data_d  = data_q;
        if (rdy[0]) begin
            valid_d[0] = IVALID;
            data_d[0]  = IVALID ? (MODE ? r : ~r) : data_q[0];
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
            end
        end
        cnt_d = cnt_q + CW'(valid_q[DEPTH-1] & OREADY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IREADY   = rdy[0];
    assign ZN       = data_q[DEPTH-1];
    assign OVALID   = valid_q[DEPTH-1];
    assign XFER_CNT = cnt_q;
endmodule
